multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multi-cycle execution core: an internal register file, data memory and adder/subtractor sequenced by a controller FSM with a start/done handshake. It executes one instruction (none, store, load, add, sub, load-immediate) per handshake and reports result, overflow and error flags. It sits between the future instruction-fetch/decode stage and the memory hierarchy, and replaces the fixed-width, unhandshaked datapath prototype.

## Interface
- WORDSIZE, 64, data word width in bits
- REG_COUNT, 32, register-file entries; power of two, ≥ 2
- MEM_DEPTH, 32, data-memory words; power of two
- RA = $clog2(REG_COUNT) and MA = $clog2(MEM_DEPTH) are localparams
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- op_code  in  7  operation: 0 none, 1 store, 2 add, 3 sub, 4 load, 5 loadi
- rs1, rs2, rd  in  RA  register addresses
- imm  in  WORDSIZE  immediate for loadi
- dbg_addr  in  RA  debug register-read address
- busy  out  1  high from acceptance until the DONE state is left
- done  out  1  one-cycle pulse in the DONE state
- result  out  WORDSIZE  value written to or read from the target
- ovf  out  1  signed overflow of the last add/sub
- error  out  1  illegal opcode or memory address out of range
- dbg_data  out  WORDSIZE  combinational read of r[dbg_addr]

## Operation
- On acceptance, op_code, rs1, rs2, rd and imm are latched. Later input changes have no effect. start is ignored while busy.
- Register semantics:
  - r0 reads as 0 and writes to it are discarded.
  - store: mem[r[rd]] ← r[rs1]; result = r[rs1].
  - load: r[rd] ← mem[r[rs1]].
  - add: r[rd] ← r[rs1] + r[rs2].
  - sub: r[rd] ← r[rs1] − r[rs2].
  - loadi: r[rd] ← imm.
- Arithmetic wraps modulo 2^WORDSIZE. ovf is the two's-complement signed overflow and is updated only by add/sub.
- Memory address is the full WORDSIZE register value. If any bit at position MA or above is set, the access is aborted and error=1; for load there is no register write and result=0.
- Illegal opcode (values 6 to 127): no state change, error=1.
- op none: completes with no effect and error=0.
- FSM states: IDLE, READ, EXEC, MEM, WB, DONE.
  - add/sub: IDLE→READ→EXEC→WB→DONE.
  - store: IDLE→READ→EXEC→MEM→DONE.
  - load: IDLE→READ→EXEC→MEM→WB→DONE.
  - loadi: IDLE→WB→DONE.
  - none or illegal: IDLE→DONE.
  - DONE→IDLE unconditionally.
- READ latches operands. EXEC computes the ALU result or the memory address and its range check. MEM performs the synchronous write, or a read whose data is registered. WB writes the register file.
- result, ovf and error hold their values until the next acceptance. error and ovf clear on acceptance.

## Timing
- Count from the accepting edge N. done is high in the cycle after:
  - N+1 for none/illegal
  - N+2 for loadi
  - N+4 for add/sub/store
  - N+5 for load
- busy rises after edge N and falls after the edge that leaves DONE. Back-to-back: start held high is next accepted on the edge where the state is IDLE again, i.e. one idle cycle minimum.
- The register-file write lands on the WB exit edge, so the value is visible on dbg_data in the DONE cycle.
- Reset values: state IDLE; busy, done, ovf, error = 0; result = 0; all registers = 0. Memory is not reset and its contents are unspecified.
- Reset mid-operation aborts immediately. No register or memory write is committed after rst_n falls.

## Structure
- Shared package multicycle_pkg holds:
  - opcode localparams OP_NONE, OP_STORE, OP_ADD, OP_SUB, OP_LOAD, OP_LOADI
  - state encodings S_IDLE, S_READ, S_EXEC, S_MEM, S_WB, S_DONE
- One sub-module, alu_addsub: parametrised WORDSIZE, combinational sum/difference plus signed overflow. The register file and memory are internal arrays.

## Test plan
- Reset, then loadi r1←5 and loadi r2←3, then add r3,r1,r2 → done at N+4; result=8, r3=8, ovf=0.
- sub r4,r2,r1 (3−5) → result=0xFFFF_FFFF_FFFF_FFFE; add with r1=0x7FFF…FFFF and r2=1 → ovf=1, result=0x8000…0000.
- With r7=9, store r4 to [r7], then load r5 from [r7] → r5=r4; done for the load at N+5. With r7=32, store → error=1 and memory unchanged.
- op_code=9 → done at N+1, error=1, no register changes. loadi to r0 with imm=0xAA → dbg_data(r0)=0.
- start pulsed while busy, plus rs1 changed mid-operation → ignored; the original operands are used.
- rst_n low in the EXEC cycle of add r6 → r6 stays 0, busy=0 and state IDLE immediately.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes and controller state encodings shared by the datapath
package multicycle_pkg;

    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_STORE = 7'd1;
    localparam logic [6:0] OP_ADD   = 7'd2;
    localparam logic [6:0] OP_SUB   = 7'd3;
    localparam logic [6:0] OP_LOAD  = 7'd4;
    localparam logic [6:0] OP_LOADI = 7'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: instruction request/response and debug read port
interface multicycle_datapath_if #(
    parameter int WORDSIZE  = 64,
    parameter int REG_COUNT = 32
);
    localparam int RA = $clog2(REG_COUNT);

    logic                start;
    logic [6:0]          op_code;
    logic [RA-1:0]       rs1;
    logic [RA-1:0]       rs2;
    logic [RA-1:0]       rd;
    logic [WORDSIZE-1:0] imm;
    logic [RA-1:0]       dbg_addr;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] result;
    logic                ovf;
    logic                error;
    logic [WORDSIZE-1:0] dbg_data;

    modport master (
        output start, op_code, rs1, rs2, rd, imm, dbg_addr,
        input  busy, done, result, ovf, error, dbg_data
    );

    modport slave (
        input  start, op_code, rs1, rs2, rd, imm, dbg_addr,
        output busy, done, result, ovf, error, dbg_data
    );

endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: wrapping add/subtract with two's-complement overflow flag
module alu_addsub #(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic                sub,
    output logic [WORDSIZE-1:0] y,
    output logic                ovf
);
    logic [WORDSIZE-1:0] bx;

    // subtract as a + ~b + 1; overflow when same-signed operands give a differently-signed sum
    always_comb begin
        bx  = sub ? ~b : b;
        y   = a + bx + {{(WORDSIZE-1){1'b0}}, sub};
        ovf = (a[WORDSIZE-1] == bx[WORDSIZE-1]) && (y[WORDSIZE-1] != a[WORDSIZE-1]);
    end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: register file, data memory and add/sub sequenced by a start/done FSM
module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int WORDSIZE  = 64,
    parameter int REG_COUNT = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_datapath_if.slave   bus
);
    localparam int RA = $clog2(REG_COUNT);
    localparam int MA = $clog2(MEM_DEPTH);

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic [6:0]          op_q;
    logic [RA-1:0]       rs1_q;
    logic [RA-1:0]       rs2_q;
    logic [RA-1:0]       rd_q;
    logic [WORDSIZE-1:0] imm_q;
    logic [WORDSIZE-1:0] a_q;
    logic [WORDSIZE-1:0] b_q;
    logic [WORDSIZE-1:0] alu_q;
    logic [WORDSIZE-1:0] mem_q;
    logic [MA-1:0]       addr_q;
    logic                addr_err_q;
    logic [WORDSIZE-1:0] result_q;
    logic                ovf_q;
    logic                error_q;
    logic [WORDSIZE-1:0] regs [REG_COUNT];
    logic [WORDSIZE-1:0] mem  [MEM_DEPTH];
    logic [WORDSIZE-1:0] alu_y;
    logic                alu_ovf;
    logic [WORDSIZE-1:0] addr_w;
    logic [WORDSIZE-1:0] wb_val;
    logic                wb_en;
    logic                is_arith;

    alu_addsub #(.WORDSIZE(WORDSIZE)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .sub (op_q == OP_SUB),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    // decode helpers: load addresses through rs1, store through rd; a failed load writes nothing
    always_comb begin
        accept   = (state == S_IDLE) && bus.start;
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        addr_w   = (op_q == OP_LOAD) ? a_q : b_q;
        wb_val   = (op_q == OP_LOADI) ? imm_q :
                   (op_q == OP_LOAD)  ? (addr_err_q ? '0 : mem_q) : alu_q;
        wb_en    = !((op_q == OP_LOAD) && addr_err_q);
    end

    // controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // controller next-state: route each opcode through only the phases it needs
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start)
                        state_nx = (bus.op_code == OP_ADD || bus.op_code == OP_SUB ||
                                    bus.op_code == OP_STORE || bus.op_code == OP_LOAD) ? S_READ :
                                   (bus.op_code == OP_LOADI) ? S_WB : S_DONE;
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = is_arith ? S_WB : S_MEM;
            S_MEM:  state_nx = (op_q == OP_LOAD) ? S_WB : S_DONE;
            S_WB:   state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // controller outputs decoded from the current state
    always_comb begin
        bus.busy = state != S_IDLE;
        bus.done = state == S_DONE;
    end

    // datapath: latch the instruction, read operands, execute, write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_NONE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            addr_q     <= '0;
            addr_err_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            error_q    <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.op_code;
                rs1_q   <= bus.rs1;
                rs2_q   <= bus.rs2;
                rd_q    <= bus.rd;
                imm_q   <= bus.imm;
                ovf_q   <= 1'b0;
                error_q <= bus.op_code > OP_LOADI;
            end
            if (state == S_READ) begin
                a_q <= regs[rs1_q];
                b_q <= regs[(op_q == OP_STORE) ? rd_q : rs2_q];
            end
            if (state == S_EXEC) begin
                alu_q      <= alu_y;
                addr_q     <= addr_w[MA-1:0];
                addr_err_q <= |addr_w[WORDSIZE-1:MA];
                if (is_arith) ovf_q <= alu_ovf;
                if (!is_arith && |addr_w[WORDSIZE-1:MA]) error_q <= 1'b1;
            end
            if (state == S_MEM && op_q == OP_STORE) result_q <= a_q;
            if (state == S_WB) begin
                result_q <= wb_val;
                if (wb_en && rd_q != '0) regs[rd_q] <= wb_val;
            end
        end
    end

    // data memory: synchronous write and registered read; out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (state == S_MEM) begin
            if (op_q == OP_STORE && !addr_err_q) mem[addr_q] <= a_q;
            mem_q <= mem[addr_q];
        end
    end

    assign bus.result   = result_q;
    assign bus.ovf      = ovf_q;
    assign bus.error    = error_q;
    assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed vector table plus handshake/reset corner sequences
module tb_multicycle_datapath;
    import multicycle_pkg::*;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [63:0] res;
        logic        ovf;
        logic        err;
        int          lat;
        logic [4:0]  dreg;
        logic [63:0] dval;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];

    multicycle_datapath_if #(.WORDSIZE(64), .REG_COUNT(32)) bus ();

    multicycle_datapath #(.WORDSIZE(64), .REG_COUNT(32), .MEM_DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [63:0] imm, input logic [63:0] res,
                                input logic ovf, input logic err, input int lat,
                                input logic [4:0] dreg, input logic [63:0] dval);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.res = res;
        v.ovf = ovf; v.err = err; v.lat = lat; v.dreg = dreg; v.dval = dval;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.op_code = v.op;
        bus.rs1     = v.rs1;
        bus.rs2     = v.rs2;
        bus.rd      = v.rd;
        bus.imm     = v.imm;
    endtask

    task automatic wait_done(inout int lat);
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_done(input string tag, input vec_t v, input int lat);
        chk({tag, "_lat"}, 64'(lat), 64'(v.lat));
        chk({tag, "_result"}, bus.result, v.res);
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(v.ovf));
        chk({tag, "_error"}, 64'(bus.error), 64'(v.err));
        bus.dbg_addr = v.dreg;
        #1;
        chk({tag, "_reg"}, bus.dbg_data, v.dval);
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run(input string tag, input vec_t v);
        int lat;
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat = 1;
        wait_done(lat);
        check_done(tag, v, lat);
    endtask

    initial begin
        vec_t v;
        int   lat;
        vt.push_back(mk(OP_LOADI, 0, 0, 1, 64'd5, 64'd5, 0, 0, 2, 1, 64'd5));
        vt.push_back(mk(OP_LOADI, 0, 0, 2, 64'd3, 64'd3, 0, 0, 2, 2, 64'd3));
        vt.push_back(mk(OP_ADD,   1, 2, 3, 64'd0, 64'd8, 0, 0, 4, 3, 64'd8));
        vt.push_back(mk(OP_SUB,   2, 1, 4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 4, 4, 64'hFFFF_FFFF_FFFF_FFFE));
        vt.push_back(mk(OP_LOADI, 0, 0, 7, 64'd9, 64'd9, 0, 0, 2, 7, 64'd9));
        vt.push_back(mk(OP_STORE, 4, 0, 7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 4, 7, 64'd9));
        vt.push_back(mk(OP_LOAD,  7, 0, 5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 5, 5, 64'hFFFF_FFFF_FFFF_FFFE));
        vt.push_back(mk(OP_LOADI, 0, 0, 8, 64'd0, 64'd0, 0, 0, 2, 8, 64'd0));
        vt.push_back(mk(OP_STORE, 3, 0, 8, 64'd0, 64'd8, 0, 0, 4, 8, 64'd0));
        vt.push_back(mk(OP_LOADI, 0, 0, 7, 64'd32, 64'd32, 0, 0, 2, 7, 64'd32));
        vt.push_back(mk(OP_STORE, 1, 0, 7, 64'd0, 64'd5, 0, 1, 4, 7, 64'd32));
        vt.push_back(mk(OP_LOAD,  8, 0, 9, 64'd0, 64'd8, 0, 0, 5, 9, 64'd8));
        vt.push_back(mk(OP_LOAD,  7, 0, 10, 64'd0, 64'd0, 0, 1, 5, 10, 64'd0));
        vt.push_back(mk(OP_LOADI, 0, 0, 10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 2, 10, 64'h7FFF_FFFF_FFFF_FFFF));
        vt.push_back(mk(OP_LOADI, 0, 0, 11, 64'd1, 64'd1, 0, 0, 2, 11, 64'd1));
        vt.push_back(mk(OP_ADD,   10, 11, 12, 64'd0, 64'h8000_0000_0000_0000, 1, 0, 4, 12, 64'h8000_0000_0000_0000));
        vt.push_back(mk(OP_SUB,   12, 11, 13, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 4, 13, 64'h7FFF_FFFF_FFFF_FFFF));
        vt.push_back(mk(7'd9,     2, 2, 1, 64'd77, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 1, 64'd5));
        vt.push_back(mk(OP_LOADI, 0, 0, 0, 64'hAA, 64'hAA, 0, 0, 2, 0, 64'd0));
        vt.push_back(mk(OP_NONE,  1, 1, 1, 64'd0, 64'hAA, 0, 0, 1, 1, 64'd5));

        bus.start = 1'b0;
        bus.op_code = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.imm = '0; bus.dbg_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_reg5", bus.dbg_data, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) run($sformatf("vec%0d", i), vt[i]);

        // start pulsed while busy and operands changed after acceptance must be ignored
        v = mk(OP_ADD, 1, 2, 14, 64'd0, 64'd8, 0, 0, 4, 14, 64'd8);
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rs1 = 5'd3; bus.rs2 = 5'd12; bus.op_code = OP_SUB; bus.rd = 5'd15; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 2;
        wait_done(lat);
        check_done("busy_ignore", v, lat);
        @(posedge clk); #1;
        chk("busy_ignore_noreq", 64'(bus.busy), 64'd0);
        bus.dbg_addr = 5'd15;
        #1;
        chk("busy_ignore_r15", bus.dbg_data, 64'd0);

        // start held high: re-accepted only after one idle cycle
        v = mk(OP_LOADI, 0, 0, 16, 64'd7, 64'd7, 0, 0, 2, 16, 64'd7);
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'd2);
        @(posedge clk); #1;
        chk("b2b_gap", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        chk("b2b_reaccept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        lat = 1;
        wait_done(lat);
        check_done("b2b_second", v, lat);

        // reset asserted during EXEC of add r6 aborts at once with no writeback
        v = mk(OP_ADD, 1, 2, 6, 64'd0, 64'd8, 0, 0, 4, 6, 64'd8);
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_exec", 64'(dut.state), 64'(S_EXEC));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_state", 64'(dut.state), 64'(S_IDLE));
        chk("abort_result", bus.result, 64'd0);
        bus.dbg_addr = 5'd1;
        #1;
        chk("abort_r1_cleared", bus.dbg_data, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        bus.dbg_addr = 5'd6;
        #1;
        chk("abort_r6", bus.dbg_data, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("post_reset", mk(OP_LOADI, 0, 0, 6, 64'h1234, 64'h1234, 0, 0, 2, 6, 64'h1234));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
